// File: rtl/ring_router_ctrl.sv
// Per-node ring router controller: header decode, three 2-way round-robin
// output arbiters, buffer strobes, VC polarity and saturating transfer counters.
module ring_router_ctrl #(
   parameter int   HOP_W         = 4,
   parameter int   CNT_W         = 16,
   parameter logic INIT_POLARITY = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cw_in_full,
   input  logic             cw_in_vc,
   input  logic [HOP_W-1:0] cw_in_hop,
   input  logic             ccw_in_full,
   input  logic             ccw_in_vc,
   input  logic [HOP_W-1:0] ccw_in_hop,
   input  logic             pe_in_full,
   input  logic             pe_in_vc,
   input  logic             pe_in_dir,
   input  logic             cw_out_empty,
   input  logic             ccw_out_empty,
   input  logic             pe_out_empty,
   output logic             cw_in_rd,
   output logic             ccw_in_rd,
   output logic             pe_in_rd,
   output logic             cw_out_wr,
   output logic             ccw_out_wr,
   output logic             pe_out_wr,
   output logic             cw_out_sel,
   output logic             ccw_out_sel,
   output logic             pe_out_sel,
   output logic             polarity,
   output logic [CNT_W-1:0] cw_out_cnt,
   output logic [CNT_W-1:0] ccw_out_cnt,
   output logic [CNT_W-1:0] pe_out_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic prio_cw, prio_ccw, prio_pe;
   logic cw_elig, ccw_elig, pe_elig;
   logic r_cw0, r_cw1, r_ccw0, r_ccw1, r_pe0, r_pe1;
   logic g_cw0, g_cw1, g_ccw0, g_ccw1, g_pe0, g_pe1;

   // A packet only competes in the phase matching its virtual channel.
   assign cw_elig  = cw_in_full  && (cw_in_vc  == polarity);
   assign ccw_elig = ccw_in_full && (ccw_in_vc == polarity);
   assign pe_elig  = pe_in_full  && (pe_in_vc  == polarity);

   assign r_pe0  = cw_elig  && (cw_in_hop  == '0);
   assign r_cw0  = cw_elig  && (cw_in_hop  != '0);
   assign r_pe1  = ccw_elig && (ccw_in_hop == '0);
   assign r_ccw0 = ccw_elig && (ccw_in_hop != '0);
   assign r_cw1  = pe_elig  && !pe_in_dir;
   assign r_ccw1 = pe_elig  &&  pe_in_dir;

   // Lone requester always wins; on contention the priority bit picks the index.
   assign g_cw0  = cw_out_empty  && r_cw0  && (!r_cw1  || !prio_cw);
   assign g_cw1  = cw_out_empty  && r_cw1  && (!r_cw0  ||  prio_cw);
   assign g_ccw0 = ccw_out_empty && r_ccw0 && (!r_ccw1 || !prio_ccw);
   assign g_ccw1 = ccw_out_empty && r_ccw1 && (!r_ccw0 ||  prio_ccw);
   assign g_pe0  = pe_out_empty  && r_pe0  && (!r_pe1  || !prio_pe);
   assign g_pe1  = pe_out_empty  && r_pe1  && (!r_pe0  ||  prio_pe);

   assign cw_out_wr   = g_cw0  | g_cw1;
   assign ccw_out_wr  = g_ccw0 | g_ccw1;
   assign pe_out_wr   = g_pe0  | g_pe1;
   assign cw_out_sel  = g_cw1;
   assign ccw_out_sel = g_ccw1;
   assign pe_out_sel  = g_pe1;

   assign cw_in_rd  = g_cw0 | g_pe0;
   assign ccw_in_rd = g_ccw0 | g_pe1;
   assign pe_in_rd  = g_cw1 | g_ccw1;

   // Priority only rotates when a contended grant was actually issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         polarity <= INIT_POLARITY;
         prio_cw  <= 1'b0;
         prio_ccw <= 1'b0;
         prio_pe  <= 1'b0;
      end else begin
         polarity <= ~polarity;
         if (cw_out_empty && r_cw0 && r_cw1)
            prio_cw <= ~prio_cw;
         if (ccw_out_empty && r_ccw0 && r_ccw1)
            prio_ccw <= ~prio_ccw;
         if (pe_out_empty && r_pe0 && r_pe1)
            prio_pe <= ~prio_pe;
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cw_out_cnt  <= '0;
         ccw_out_cnt <= '0;
         pe_out_cnt  <= '0;
      end else begin
         if (cw_out_wr && (cw_out_cnt != CNT_MAX))
            cw_out_cnt <= cw_out_cnt + CNT_ONE;
         if (ccw_out_wr && (ccw_out_cnt != CNT_MAX))
            ccw_out_cnt <= ccw_out_cnt + CNT_ONE;
         if (pe_out_wr && (pe_out_cnt != CNT_MAX))
            pe_out_cnt <= pe_out_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_ring_router_ctrl.sv
// Directed bench for ring_router_ctrl; a narrow counter width keeps the
// saturation scenario short.
module tb_ring_router_ctrl;

   localparam int HOP_W = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cw_in_full, cw_in_vc;
   logic [HOP_W-1:0] cw_in_hop;
   logic             ccw_in_full, ccw_in_vc;
   logic [HOP_W-1:0] ccw_in_hop;
   logic             pe_in_full, pe_in_vc, pe_in_dir;
   logic             cw_out_empty, ccw_out_empty, pe_out_empty;
   logic             cw_in_rd, ccw_in_rd, pe_in_rd;
   logic             cw_out_wr, ccw_out_wr, pe_out_wr;
   logic             cw_out_sel, ccw_out_sel, pe_out_sel;
   logic             polarity;
   logic [CNT_W-1:0] cw_out_cnt, ccw_out_cnt, pe_out_cnt;
   logic [8:0]       strb;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_pol  = 1'b0;
   logic [CNT_W-1:0] exp_cw = '0, exp_ccw = '0, exp_pe = '0;

   ring_router_ctrl #(.HOP_W(HOP_W), .CNT_W(CNT_W), .INIT_POLARITY(1'b0)) dut (
      .clk(clk), .reset(reset),
      .cw_in_full(cw_in_full), .cw_in_vc(cw_in_vc), .cw_in_hop(cw_in_hop),
      .ccw_in_full(ccw_in_full), .ccw_in_vc(ccw_in_vc), .ccw_in_hop(ccw_in_hop),
      .pe_in_full(pe_in_full), .pe_in_vc(pe_in_vc), .pe_in_dir(pe_in_dir),
      .cw_out_empty(cw_out_empty), .ccw_out_empty(ccw_out_empty), .pe_out_empty(pe_out_empty),
      .cw_in_rd(cw_in_rd), .ccw_in_rd(ccw_in_rd), .pe_in_rd(pe_in_rd),
      .cw_out_wr(cw_out_wr), .ccw_out_wr(ccw_out_wr), .pe_out_wr(pe_out_wr),
      .cw_out_sel(cw_out_sel), .ccw_out_sel(ccw_out_sel), .pe_out_sel(pe_out_sel),
      .polarity(polarity),
      .cw_out_cnt(cw_out_cnt), .ccw_out_cnt(ccw_out_cnt), .pe_out_cnt(pe_out_cnt)
   );

   always #5 clk = ~clk;

   // Bit order: in_rd cw/ccw/pe, out_wr cw/ccw/pe, out_sel cw/ccw/pe.
   assign strb = {cw_in_rd, ccw_in_rd, pe_in_rd, cw_out_wr, ccw_out_wr, pe_out_wr,
                  cw_out_sel, ccw_out_sel, pe_out_sel};

   task automatic tick;
      @(posedge clk);
      exp_pol = reset ? 1'b0 : ~exp_pol;
      #1;
   endtask

   task automatic idle;
      cw_in_full = 0; cw_in_vc = 0; cw_in_hop = '0;
      ccw_in_full = 0; ccw_in_vc = 0; ccw_in_hop = '0;
      pe_in_full = 0; pe_in_vc = 0; pe_in_dir = 0;
      cw_out_empty = 1; ccw_out_empty = 1; pe_out_empty = 1;
   endtask

   task automatic align(input logic p);
      if (exp_pol != p) tick();
   endtask

   task automatic test_reset;
      logic [3:0] pol_seq;
      pol_seq = 4'b1010;
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (polarity !== pol_seq[i]) begin
            n_fail++; $display("[TB] FAIL reset_polarity[%0d]: got %b expected %b", i, polarity, pol_seq[i]);
         end
         n_checks++;
         if (strb !== 9'b0) begin
            n_fail++; $display("[TB] FAIL reset_strobes[%0d]: got %b expected 0", i, strb);
         end
         n_checks++;
         if ({cw_out_cnt, ccw_out_cnt, pe_out_cnt} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_counters[%0d]: got %h/%h/%h expected 0", i, cw_out_cnt, ccw_out_cnt, pe_out_cnt);
         end
         tick();
      end
   endtask

   task automatic test_cw_pass;
      idle(); align(0);
      cw_in_full = 1; cw_in_vc = 0; cw_in_hop = 4'd3;
      #1;
      n_checks++;
      if (strb !== 9'b100100000) begin
         n_fail++; $display("[TB] FAIL cw_pass_strobes: got %b expected %b", strb, 9'b100100000);
      end
      tick(); exp_cw = 4'd1;
      n_checks++;
      if (strb !== 9'b0) begin
         n_fail++; $display("[TB] FAIL cw_pass_wrong_vc: got %b expected 0", strb);
      end
      n_checks++;
      if (cw_out_cnt !== 4'd1) begin
         n_fail++; $display("[TB] FAIL cw_pass_cnt: got %0d expected 1", cw_out_cnt);
      end
      tick();
   endtask

   task automatic test_pe_alternate;
      logic [8:0] want;
      idle(); align(0);
      cw_in_full = 1; cw_in_hop = '0;
      ccw_in_full = 1; ccw_in_hop = '0;
      for (int i = 0; i < 4; i++) begin
         want = (i % 2 == 0) ? 9'b100001000 : 9'b010001001;
         #1;
         n_checks++;
         if (strb !== want) begin
            n_fail++; $display("[TB] FAIL pe_alternate[%0d]: got %b expected %b", i, strb, want);
         end
         tick(); exp_pe = exp_pe + 4'd1;
         n_checks++;
         if (strb !== 9'b0) begin
            n_fail++; $display("[TB] FAIL pe_alternate_odd[%0d]: got %b expected 0", i, strb);
         end
         tick();
      end
      n_checks++;
      if (pe_out_cnt !== 4'd4) begin
         n_fail++; $display("[TB] FAIL pe_alternate_cnt: got %0d expected 4", pe_out_cnt);
      end
   endtask

   task automatic test_stall;
      idle(); align(0);
      cw_in_full = 1; cw_in_hop = 4'd2;
      pe_in_full = 1; pe_in_dir = 0;
      cw_out_empty = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (strb !== 9'b0) begin
            n_fail++; $display("[TB] FAIL stall[%0d]: got %b expected 0", i, strb);
         end
         tick(); tick();
      end
      cw_out_empty = 1;
      #1;
      n_checks++;
      if (strb !== 9'b100100000) begin
         n_fail++; $display("[TB] FAIL stall_release_cw: got %b expected %b", strb, 9'b100100000);
      end
      tick(); tick(); exp_cw = exp_cw + 4'd1;
      n_checks++;
      if (strb !== 9'b001100100) begin
         n_fail++; $display("[TB] FAIL stall_release_pe: got %b expected %b", strb, 9'b001100100);
      end
      tick(); tick(); exp_cw = exp_cw + 4'd1;
      n_checks++;
      if (cw_out_cnt !== 4'd3) begin
         n_fail++; $display("[TB] FAIL stall_cnt: got %0d expected 3", cw_out_cnt);
      end
   endtask

   task automatic test_ccw_route;
      idle(); align(1);
      pe_in_full = 1; pe_in_vc = 1; pe_in_dir = 1;
      #1;
      n_checks++;
      if (strb !== 9'b001010010) begin
         n_fail++; $display("[TB] FAIL ccw_route: got %b expected %b", strb, 9'b001010010);
      end
      tick(); exp_ccw = exp_ccw + 4'd1;
      n_checks++;
      if (ccw_out_cnt !== 4'd1) begin
         n_fail++; $display("[TB] FAIL ccw_route_cnt: got %0d expected 1", ccw_out_cnt);
      end
   endtask

   task automatic test_back_to_back;
      idle(); align(0);
      cw_in_full = 1; cw_in_hop = '0;
      ccw_in_full = 1; ccw_in_hop = 4'd5;
      pe_in_full = 1; pe_in_dir = 0;
      #1;
      n_checks++;
      if (strb !== 9'b111111100) begin
         n_fail++; $display("[TB] FAIL all_grant: got %b expected %b", strb, 9'b111111100);
      end
      tick();
      n_checks++;
      if ({cw_out_cnt, ccw_out_cnt, pe_out_cnt} !== {4'd4, 4'd2, 4'd5}) begin
         n_fail++; $display("[TB] FAIL all_grant_cnt: got %0d/%0d/%0d expected 4/2/5", cw_out_cnt, ccw_out_cnt, pe_out_cnt);
      end
      exp_cw = exp_cw + 4'd1; exp_ccw = exp_ccw + 4'd1; exp_pe = exp_pe + 4'd1;
      tick();
   endtask

   task automatic test_saturate;
      idle(); align(0);
      cw_in_full = 1; cw_in_hop = '0;
      while (exp_pe < 4'd14) begin
         tick(); tick();
         exp_pe = exp_pe + 4'd1;
      end
      n_checks++;
      if (pe_out_cnt !== 4'd14) begin
         n_fail++; $display("[TB] FAIL sat_preload: got %0d expected 14", pe_out_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pe_out_cnt !== 4'hF) begin
            n_fail++; $display("[TB] FAIL sat_hold[%0d]: got %0d expected 15", i, pe_out_cnt);
         end
         tick();
      end
      n_checks++;
      if (cw_out_cnt !== exp_cw) begin
         n_fail++; $display("[TB] FAIL sat_cw_untouched: got %0d expected %0d", cw_out_cnt, exp_cw);
      end
      reset = 1;
      tick();
      idle();
      reset = 0;
      #1;
      n_checks++;
      if ({cw_out_cnt, ccw_out_cnt, pe_out_cnt} !== '0) begin
         n_fail++; $display("[TB] FAIL midreset_cnt: got %0d/%0d/%0d expected 0", cw_out_cnt, ccw_out_cnt, pe_out_cnt);
      end
      n_checks++;
      if (polarity !== 1'b0) begin
         n_fail++; $display("[TB] FAIL midreset_polarity: got %b expected 0", polarity);
      end
      tick();
      n_checks++;
      if (polarity !== 1'b1) begin
         n_fail++; $display("[TB] FAIL postreset_toggle: got %b expected 1", polarity);
      end
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_cw_pass();
      test_pe_alternate();
      test_stall();
      test_ccw_route();
      test_back_to_back();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_router_ctrl.md
Name: ring_router_ctrl

Overview:
- Per-node controller for the bidirectional ring router.
- Decodes the headers of the three input-buffer packets (CW_in, CCW_in, PE_in) into output requests.
- Resolves contention on the CW_out, CCW_out and PE_out buffers with three 2-way round-robin arbiters.
- Drives the buffer read, write and mux-select strobes, keeps the odd/even virtual-channel polarity, and maintains per-output transfer counters.

Parameters:
- HOP_W, 4: width of the header hop-count field.
- CNT_W, 16: width of each saturating per-output transfer counter.
- INIT_POLARITY, 1'b0: value loaded into polarity on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cw_in_full  in  1  CW input buffer holds a packet
- cw_in_vc  in  1  VC bit of the CW input packet
- cw_in_hop  in  HOP_W  remaining hops of the CW input packet; 0 = deliver to PE
- ccw_in_full  in  1  CCW input buffer holds a packet
- ccw_in_vc  in  1  VC bit of the CCW input packet
- ccw_in_hop  in  HOP_W  remaining hops of the CCW input packet; 0 = deliver to PE
- pe_in_full  in  1  PE input buffer holds a packet
- pe_in_vc  in  1  VC bit of the PE input packet
- pe_in_dir  in  1  injection direction of the PE packet; 0 = CW, 1 = CCW
- cw_out_empty, ccw_out_empty, pe_out_empty  in  1 each  output buffer is free
- cw_in_rd, ccw_in_rd, pe_in_rd  out  1 each  pop the input buffer this cycle
- cw_out_wr, ccw_out_wr, pe_out_wr  out  1 each  write the output buffer this cycle
- cw_out_sel  out  1  CW_out source; 0 = CW_in, 1 = PE_in
- ccw_out_sel  out  1  CCW_out source; 0 = CCW_in, 1 = PE_in
- pe_out_sel  out  1  PE_out source; 0 = CW_in, 1 = CCW_in
- polarity  out  1  current VC phase
- cw_out_cnt, ccw_out_cnt, pe_out_cnt  out  CNT_W each  packets written per output

Behaviour:
- State registers: polarity; three priority bits (prio_cw, prio_ccw, prio_pe); three counters.
- Reset (synchronous, active-high):
  - polarity <= INIT_POLARITY.
  - All priority bits <= 0.
  - All counters <= 0.
  - All strobes are combinational and therefore 0 while no request is qualified.
- Polarity: toggles every cycle after reset.
- Request qualification: an input packet is eligible only if its buffer is full and its vc == polarity.
- Request decode:
  - CW_in eligible, hop==0 -> requests PE_out (r_pe0); otherwise requests CW_out (r_cw0).
  - CCW_in eligible, hop==0 -> requests PE_out (r_pe1); otherwise requests CCW_out (r_ccw0).
  - PE_in eligible -> requests CW_out (r_cw1) if dir=0, or CCW_out (r_ccw1) if dir=1.
  - Each input raises at most one request per cycle, so grants never conflict on an input.
- Arbitration per output X, active only when X_out_empty:
  - Exactly one request -> it wins.
  - Two requests -> prio_X = 0 selects index 0, prio_X = 1 selects index 1.
  - prio_X flips at the clock edge only in cycles where both requests were present and X_out_empty = 1.
  - No requests, or output not empty -> no grant, prio_X unchanged.
- Grant outputs, zero-latency combinational within the cycle:
  - X_out_wr = 1 on any grant for output X.
  - X_out_sel = index of the winner; 0 when there is no grant.
  - The winning input's *_in_rd = 1.
- Data transfer (buffer pop/push) occurs at the same clock edge as the strobes.
- Counters:
  - X_out_cnt increments on each X_out_wr.
  - Saturates at all-ones; no wrap.
- Full output buffer: its requesters stall; their input buffers are not popped.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight strobe in the reset cycle is don't-care for the datapath, since the buffers also reset.

Test Plan:
- Reset, all inputs idle for 4 cycles -> polarity = 0,1,0,1; every strobe 0; all counters 0.
- CW_in full (vc=0, hop=3), cw_out_empty=1, at polarity=0 -> cw_in_rd=1, cw_out_wr=1, cw_out_sel=0 in that cycle; cw_out_cnt = 1 next cycle. With polarity=1 -> no strobes.
- CW_in (hop=0) and CCW_in (hop=0) both vc=0, pe_out_empty held 1, held for 4 even cycles -> PE_out winners alternate CW, CCW, CW, CCW (pe_out_sel = 0,1,0,1); prio_pe flips each time.
- CW_in (hop=2) and PE_in (dir=0) contend with cw_out_empty=0 for 3 cycles, then 1 -> no grants while not empty; CW_in wins first, priority unchanged during the stall.
- Simultaneous CW_in (hop=0) to PE_out, CCW_in (hop=5) to CCW_out, PE_in (dir=0) to CW_out, all outputs empty -> all three granted in one cycle; all three counters +1.
- Preload a counter to 2^CNT_W-2, then 3 writes -> counter reads all-ones and holds; assert reset mid-stream -> counters 0, polarity = INIT_POLARITY.
